// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared width default, counter width and the FSM / requester
// enums used by mem_arbiter and mem_arb_pick.
package mem_arb_pkg;

  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selection between fetch and data ports.
// Round-robin tie-break with MEM_ARB_ROUND_ROBIN_EN, fixed data priority otherwise.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_t i_last,
  output req_id_t o_winner
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic w_unused_last;
  assign w_unused_last = i_last;
`endif

  always_comb begin
    o_winner = REQ_D;
    if (i_req && !d_req) begin
      o_winner = REQ_I;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    else if (i_req && d_req && (i_last == REQ_D)) begin
      o_winner = REQ_I;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a data port onto one fixed-latency
// backing memory. Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module mem_arbiter #(
  parameter int unsigned WORD_SIZE = mem_arb_pkg::WORD_SIZE,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 m_read,
  output logic                 m_write,
  output logic [WORD_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  output logic                 busy
);

  import mem_arb_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 32'd1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  req_id_t              r_id;
  req_id_t              w_winner;
  req_id_t              w_last;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_i_data;
  logic [WORD_SIZE-1:0] r_d_rdata;
  logic                 r_we;
  logic                 r_dropped;
  logic                 r_i_ready;
  logic                 r_d_ready;
  logic                 w_grant;
  logic                 w_last_cyc;
  logic                 w_owner_req;
  logic                 w_deliver;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_t r_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= REQ_I;
    end else if (w_grant) begin
      r_last <= w_winner;
    end
  end

  assign w_last = r_last;
`else
  assign w_last = REQ_I;
`endif

  mem_arb_pick u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .i_last   (w_last),
    .o_winner (w_winner)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_last_cyc  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req || d_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cnt == LAST_CNT) begin
          w_last_cyc  = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A requester that lets go at any point in ACCESS forfeits its response,
  // but the memory access itself still runs to completion.
  assign w_owner_req = (r_id == REQ_I) ? i_req : d_req;
  assign w_deliver   = w_last_cyc && w_owner_req && !r_dropped;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_id      <= REQ_I;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_dropped <= 1'b0;
      r_i_data  <= '0;
      r_d_rdata <= '0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      if (w_grant) begin
        r_id      <= w_winner;
        r_cnt     <= '0;
        r_dropped <= 1'b0;
        if (w_winner == REQ_D) begin
          r_addr  <= d_addr;
          r_we    <= d_we;
          r_wdata <= d_wdata;
        end else begin
          r_addr  <= i_addr;
          r_we    <= 1'b0;
          r_wdata <= '0;
        end
      end
      if (r_state == ACCESS) begin
        r_cnt <= r_cnt + 1'b1;
        if (!w_owner_req) begin
          r_dropped <= 1'b1;
        end
      end
      if (w_deliver) begin
        if (r_id == REQ_I) begin
          r_i_ready <= 1'b1;
          r_i_data  <= m_rdata;
        end else begin
          r_d_ready <= 1'b1;
          if (!r_we) begin
            r_d_rdata <= m_rdata;
          end
        end
      end
    end
  end

  assign m_read  = (r_state == ACCESS) && !r_we;
  assign m_write = w_last_cyc && r_we;
  assign m_addr  = (r_state == ACCESS) ? r_addr : '0;
  assign m_wdata = ((r_state == ACCESS) && r_we) ? r_wdata : '0;
  assign busy    = (r_state != IDLE);
  assign i_ready = r_i_ready;
  assign d_ready = r_d_ready;
  assign i_data  = r_i_data;
  assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand sequences for ties, drops and
// reset, then randomized traffic checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned W   = 16;
  localparam int unsigned LAT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_req;
  logic [W-1:0] i_addr;
  logic [W-1:0] i_data;
  logic         i_ready;
  logic         d_req;
  logic         d_we;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic [W-1:0] d_rdata;
  logic         d_ready;
  logic         m_read;
  logic         m_write;
  logic [W-1:0] m_addr;
  logic [W-1:0] m_wdata;
  logic [W-1:0] m_rdata;
  logic         busy;

  logic [W-1:0] bmem [0:255];
  logic [W-1:0] rmem [0:255];

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned n_overlap = 0;
  int unsigned cyc = 0;
  logic [W-1:0] i_hold = '0;
  logic [W-1:0] d_hold = '0;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          preload;
    logic [15:0] pre_val;
    logic [15:0] exp_data;
    int unsigned exp_nread;
    int unsigned exp_nwrite;
  } vec_t;

  vec_t vecs [7];

  int unsigned ord_cyc [4];
  bit          ord_d   [4];
  bit          exp_ord [4];
  int unsigned nresp;

  mem_arbiter #(.WORD_SIZE(W), .LATENCY(LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_data  (i_data),
    .i_ready (i_ready),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .m_read  (m_read),
    .m_write (m_write),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  assign m_rdata = bmem[m_addr[7:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Backing memory commits a write sampled mid-cycle at the following edge.
  task automatic tick();
    logic       wr;
    logic [7:0] wa;
    logic [W-1:0] wd;
    @(negedge clk);
    wr = m_write;
    wa = m_addr[7:0];
    wd = m_wdata;
    if (m_read && m_write) n_overlap++;
    @(posedge clk);
    #1;
    if (wr) bmem[wa] = wd;
    cyc++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_i_data"},  32'(i_data),  32'h0);
    check({tag, "_d_rdata"}, 32'(d_rdata), 32'h0);
    check({tag, "_i_ready"}, 32'(i_ready), 32'h0);
    check({tag, "_d_ready"}, 32'(d_ready), 32'h0);
    check({tag, "_m_read"},  32'(m_read),  32'h0);
    check({tag, "_m_write"}, 32'(m_write), 32'h0);
    check({tag, "_m_addr"},  32'(m_addr),  32'h0);
    check({tag, "_m_wdata"}, 32'(m_wdata), 32'h0);
    check({tag, "_busy"},    32'(busy),    32'h0);
  endtask

  task automatic run_txn(input bit is_d, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, output int unsigned lat,
                         output logic [15:0] data, output int unsigned nrd,
                         output int unsigned nwr, output logic [15:0] wa,
                         output logic [15:0] wd, output int unsigned nother);
    bit got = 1'b0;
    lat = 0; nrd = 0; nwr = 0; nother = 0;
    wa = '0; wd = '0; data = '0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      lat++;
      if (m_read) nrd++;
      if (m_write) begin
        nwr++; wa = m_addr; wd = m_wdata;
      end
      if (is_d ? d_ready : i_ready) begin
        got = 1'b1;
        data = is_d ? d_rdata : i_data;
      end
      if (is_d ? i_ready : d_ready) nother++;
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick();
  endtask

  initial begin
    int unsigned lat, nrd, nwr, nother, nrdy, i_cyc, d_cyc;
    logic [15:0] data, wa, wd;
    bit pend_i, pend_d, m_act, m_isd, m_we, last_d, isd, ei, ed;
    int unsigned m_rdy, m_idle, m_grant;
    logic [15:0] m_dat;
    logic [7:0]  ra;

    for (int a = 0; a < 256; a++) bmem[a] = 16'(a * 3);
    reset = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    vecs[0] = '{1'b0, 1'b0, 16'h0023, 16'h0000, 1'b1, 16'h6000, 16'h6000, 4, 0};
    vecs[1] = '{1'b1, 1'b1, 16'h00F0, 16'hBEEF, 1'b0, 16'h0000, 16'h0000, 0, 1};
    vecs[2] = '{1'b1, 1'b0, 16'h00F0, 16'h0000, 1'b0, 16'h0000, 16'hBEEF, 4, 0};
    vecs[3] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 1'b1, 16'h1234, 16'h1234, 4, 0};
    vecs[4] = '{1'b1, 1'b0, 16'h007F, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF, 4, 0};
    vecs[5] = '{1'b1, 1'b1, 16'h0010, 16'hA5A5, 1'b1, 16'h1111, 16'h0000, 0, 1};
    vecs[6] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 16'hA5A5, 4, 0};

    tick(); tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].preload) bmem[vecs[v].addr[7:0]] = vecs[v].pre_val;
      run_txn(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata,
              lat, data, nrd, nwr, wa, wd, nother);
      check($sformatf("v%0d_latency", v), lat, LAT + 1);
      check($sformatf("v%0d_nread", v), nrd, vecs[v].exp_nread);
      check($sformatf("v%0d_nwrite", v), nwr, vecs[v].exp_nwrite);
      check($sformatf("v%0d_other_ready", v), nother, 0);
      if (vecs[v].we) begin
        check($sformatf("v%0d_waddr", v), 32'(wa), 32'(vecs[v].addr));
        check($sformatf("v%0d_wdata", v), 32'(wd), 32'(vecs[v].wdata));
      end else begin
        check($sformatf("v%0d_rdata", v), 32'(data), 32'(vecs[v].exp_data));
        if (vecs[v].is_d) d_hold = vecs[v].exp_data;
        else i_hold = vecs[v].exp_data;
      end
      check($sformatf("v%0d_i_hold", v), 32'(i_data), 32'(i_hold));
      check($sformatf("v%0d_d_hold", v), 32'(d_rdata), 32'(d_hold));
      check($sformatf("v%0d_idle", v), 32'(busy), 32'h0);
    end

    // Single tie: data first, fetch granted in the IDLE cycle after D's RESP.
    i_cyc = 0; d_cyc = 0;
    i_req = 1'b1; i_addr = 16'h0001; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h007F;
    for (int k = 1; k <= 30 && (i_cyc == 0 || d_cyc == 0); k++) begin
      tick();
      if (d_ready && d_cyc == 0) begin d_cyc = k; d_hold = d_rdata; d_req = 1'b0; end
      if (i_ready && i_cyc == 0) begin i_cyc = k; i_hold = i_data; i_req = 1'b0; end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("tie_d_cycle", d_cyc, LAT + 1);
    check("tie_i_cycle", i_cyc, 2 * LAT + 3);
    check("tie_d_data", 32'(d_hold), 32'hFFFF);
    check("tie_i_data", 32'(i_hold), 32'h1234);
    tick();

    // Repeated ties with both requests held throughout.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_ord[0] = 1'b1; exp_ord[1] = 1'b0; exp_ord[2] = 1'b1; exp_ord[3] = 1'b0;
`else
    exp_ord[0] = 1'b1; exp_ord[1] = 1'b1; exp_ord[2] = 1'b1; exp_ord[3] = 1'b1;
`endif
    for (int r = 0; r < 4; r++) begin ord_cyc[r] = 0; ord_d[r] = 1'b0; end
    nresp = 0;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 1; k <= 40 && nresp < 4; k++) begin
      tick();
      if (d_ready && nresp < 4) begin ord_d[nresp] = 1'b1; ord_cyc[nresp] = k; nresp++; end
      if (i_ready && nresp < 4) begin ord_d[nresp] = 1'b0; ord_cyc[nresp] = k; nresp++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    check("ties_idle", 32'(busy), 32'h0);
    for (int r = 0; r < 4; r++) begin
      check($sformatf("ties_order%0d", r), 32'(ord_d[r]), 32'(exp_ord[r]));
      check($sformatf("ties_cycle%0d", r), ord_cyc[r], (LAT + 1) + r * (LAT + 2));
    end

    // Fetch dropped in the 2nd ACCESS cycle.
    bmem[8'h23] = 16'h7777;
    nrdy = 0;
    i_req = 1'b1; i_addr = 16'h0023;
    tick(); tick();
    i_req = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      if (i_ready) nrdy++;
      if (k == 5) check("idrop_busy_c5", 32'(busy), 32'h1);
      if (k == 6) check("idrop_idle_c6", 32'(busy), 32'h0);
      if (k < 7) tick();
    end
    check("idrop_no_ready", nrdy, 0);
    check("idrop_i_hold", 32'(i_data), 32'(i_hold));

    // Write dropped in the 2nd ACCESS cycle still commits.
    nrdy = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h4321;
    tick(); tick();
    d_req = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      if (d_ready) nrdy++;
      if (k < 7) tick();
    end
    d_we = 1'b0;
    check("wdrop_no_ready", nrdy, 0);
    check("wdrop_committed", 32'(bmem[8'h40]), 32'h4321);
    check("wdrop_d_hold", 32'(d_rdata), 32'(d_hold));

    // Reset in the 2nd ACCESS cycle of a write aborts it.
    bmem[8'h50] = 16'h0BAD;
    nwr = 0; nrdy = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0050; d_wdata = 16'h5555;
    tick();
    if (m_write) nwr++;
    if (d_ready) nrdy++;
    tick();
    if (m_write) nwr++;
    if (d_ready) nrdy++;
    reset = 1'b1;
    tick();
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    check_zero("rstwr");
    tick();
    if (m_write) nwr++;
    if (d_ready) nrdy++;
    check("rstwr_no_mwrite", nwr, 0);
    check("rstwr_no_ready", nrdy, 0);
    check("rstwr_mem_intact", 32'(bmem[8'h50]), 32'h0BAD);
    check("rstwr_idle", 32'(busy), 32'h0);
    i_hold = '0; d_hold = '0;

    // Random traffic against a transaction-level model.
    for (int a = 0; a < 256; a++) rmem[a] = bmem[a];
    pend_i = 1'b0; pend_d = 1'b0; m_act = 1'b0; m_isd = 1'b0; m_we = 1'b0;
    last_d = 1'b0; m_rdy = 0; m_grant = 0; m_idle = cyc; m_dat = '0;
    for (int c = 0; c < 600; c++) begin
      ei = m_act && !m_isd && (cyc == m_rdy);
      ed = m_act && m_isd && (cyc == m_rdy);
      check("rnd_i_ready", 32'(i_ready), 32'(ei));
      check("rnd_d_ready", 32'(d_ready), 32'(ed));
      check("rnd_busy", 32'(busy), 32'(m_act && (cyc > m_grant)));
      if (ei) begin i_hold = m_dat; pend_i = 1'b0; m_act = 1'b0; end
      if (ed) begin
        if (!m_we) d_hold = m_dat;
        pend_d = 1'b0; m_act = 1'b0;
      end
      check("rnd_i_data", 32'(i_data), 32'(i_hold));
      check("rnd_d_rdata", 32'(d_rdata), 32'(d_hold));
      if (c >= 450 && !pend_i && !pend_d && !m_act) break;
      if (c < 450) begin
        if (!pend_i && $urandom_range(0, 2) == 0) begin
          pend_i = 1'b1;
          i_addr = 16'($urandom_range(0, 15));
        end
        if (!pend_d && $urandom_range(0, 2) == 0) begin
          pend_d = 1'b1;
          d_addr = 16'($urandom_range(0, 15));
          d_we = 1'($urandom_range(0, 1));
          d_wdata = 16'($urandom);
        end
      end
      i_req = pend_i;
      d_req = pend_d;
      if (!m_act && cyc >= m_idle && (pend_i || pend_d)) begin
        isd = pend_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (pend_i && pend_d) isd = !last_d;
`endif
        last_d = isd;
        m_act = 1'b1; m_isd = isd; m_grant = cyc;
        m_rdy = cyc + LAT + 1; m_idle = cyc + LAT + 2;
        ra = isd ? d_addr[7:0] : i_addr[7:0];
        m_we = isd && d_we;
        if (m_we) rmem[ra] = d_wdata;
        else m_dat = rmem[ra];
      end
      tick();
    end
    check("rnd_drained", 32'(pend_i || pend_d || m_act), 32'h0);
    for (int a = 0; a < 16; a++)
      check($sformatf("rnd_mem%0d", a), 32'(bmem[a]), 32'(rmem[a]));
    check("strobe_exclusive", n_overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
